// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - shared types and constants for the write-through cache memory arbiter
package wt_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2
  } arb_state_e;

  // Must track the I$ refill transaction ID (RdTxId).
  localparam int unsigned IcacheTid = 0;

endpackage

// File: rtl/wt_tx_counter.sv
// rtl/wt_tx_counter.sv - saturating up/down in-flight transaction counter
module wt_tx_counter #(
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [CntWidth-1:0] cnt_q;

  assign full_o  = (cnt_q == CntWidth'(MaxOutstanding));
  assign empty_o = (cnt_q == '0);

  // Simultaneous inc and dec cancel out; both directions saturate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_q <= cnt_q - CntWidth'(1);
    end
  end

  underflow_chk : assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && empty_o))
    else $error("wt_tx_counter: return with no transaction outstanding");

  overflow_chk : assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && full_o))
    else $error("wt_tx_counter: issue beyond the outstanding limit");

endmodule

// File: rtl/wt_mem_arbiter.sv
// rtl/wt_mem_arbiter.sv - round-robin arbiter sharing the memory port between I$ and D$
module wt_mem_arbiter
  import wt_cache_pkg::arb_state_e;
  import wt_cache_pkg::IDLE;
  import wt_cache_pkg::GNT_IC;
  import wt_cache_pkg::GNT_DC;
#(
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned RtrnWidth      = 192,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned IcacheTid      = wt_cache_pkg::IcacheTid,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ic_req_i,
  input  logic [ReqWidth-1:0]  ic_data_i,
  output logic                 ic_ack_o,
  input  logic                 dc_req_i,
  input  logic [ReqWidth-1:0]  dc_data_i,
  input  logic [TidWidth-1:0]  dc_tid_i,
  output logic                 dc_ack_o,
  output logic                 mem_req_o,
  output logic [ReqWidth-1:0]  mem_data_o,
  output logic [TidWidth-1:0]  mem_tid_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rtrn_vld_i,
  input  logic [TidWidth-1:0]  mem_rtrn_tid_i,
  input  logic [RtrnWidth-1:0] mem_rtrn_i,
  output logic                 ic_rtrn_vld_o,
  output logic                 dc_rtrn_vld_o,
  output logic [RtrnWidth-1:0] rtrn_o,
  input  logic                 drain_i,
  output logic                 idle_o
);

  localparam logic [TidWidth-1:0] IcTid = TidWidth'(IcacheTid);

  arb_state_e state_q, state_d;
  logic       prefer_dc_q, prefer_dc_d;
  logic       ic_full, ic_empty, dc_full, dc_empty;
  logic       ic_eligible, dc_eligible;
  logic       rtrn_is_ic;

  assign ic_eligible = ic_req_i && !ic_full && !drain_i;
  assign dc_eligible = dc_req_i && !dc_full && !drain_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      prefer_dc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prefer_dc_q <= prefer_dc_d;
    end
  end

  // Grant is held until the adapter acks; the return to IDLE costs one bubble per grant.
  always_comb begin
    state_d     = state_q;
    prefer_dc_d = prefer_dc_q;
    mem_req_o   = 1'b0;
    mem_data_o  = '0;
    mem_tid_o   = IcTid;
    ic_ack_o    = 1'b0;
    dc_ack_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ic_eligible && (!dc_eligible || !prefer_dc_q)) begin
          state_d = GNT_IC;
        end else if (dc_eligible) begin
          state_d = GNT_DC;
        end
      end
      GNT_IC: begin
        mem_req_o  = 1'b1;
        mem_data_o = ic_data_i;
        mem_tid_o  = IcTid;
        ic_ack_o   = mem_ack_i;
        if (mem_ack_i) begin
          state_d     = IDLE;
          prefer_dc_d = 1'b1;
        end
      end
      GNT_DC: begin
        mem_req_o  = 1'b1;
        mem_data_o = dc_data_i;
        mem_tid_o  = dc_tid_i;
        dc_ack_o   = mem_ack_i;
        if (mem_ack_i) begin
          state_d     = IDLE;
          prefer_dc_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rtrn_is_ic    = (mem_rtrn_tid_i == IcTid);
  assign ic_rtrn_vld_o = mem_rtrn_vld_i && rtrn_is_ic;
  assign dc_rtrn_vld_o = mem_rtrn_vld_i && !rtrn_is_ic;
  assign rtrn_o        = mem_rtrn_i;

  wt_tx_counter #(
    .MaxOutstanding(MaxOutstanding)
  ) u_ic_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (ic_ack_o),
    .dec_i  (ic_rtrn_vld_o),
    .full_o (ic_full),
    .empty_o(ic_empty)
  );

  wt_tx_counter #(
    .MaxOutstanding(MaxOutstanding)
  ) u_dc_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (dc_ack_o),
    .dec_i  (dc_rtrn_vld_o),
    .full_o (dc_full),
    .empty_o(dc_empty)
  );

  assign idle_o = (state_q == IDLE) && ic_empty && dc_empty;

  dc_tid_chk : assert property (@(posedge clk_i) disable iff (rst_i)
    dc_req_i |-> (dc_tid_i != IcTid))
    else $error("wt_mem_arbiter: D$ request carries the I$ transaction ID");

endmodule
